// File: rtl/dma_pkg.sv
// Shared definitions for the DMA reader/writer pair: default sizes, the
// transfer FSM state type and the word-count clamp.
package dma_pkg;

  localparam int WORD_SIZE         = 16;
  localparam int MEM_ADDRESS_WIDTH = 3;
  localparam int BUFFER_SIZE       = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } dma_state_t;

  // A request can never move more words than the source buffer holds.
  function automatic int clamp_count(input int count, input int buffer_size);
    return (count > buffer_size) ? buffer_size : count;
  endfunction

endpackage

// File: rtl/dma_writer.sv
// Drains a packed word buffer into word-addressed memory, one word per cycle,
// using the same start-level / o_ready handshake as the DMA reader.
module dma_writer #(
  parameter int BUFFER_SIZE       = dma_pkg::BUFFER_SIZE,
  parameter int WORD_SIZE         = dma_pkg::WORD_SIZE,
  parameter int MEM_ADDRESS_WIDTH = dma_pkg::MEM_ADDRESS_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]           i_address,
  input  logic [MEM_ADDRESS_WIDTH:0]             i_count,
  input  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0]  i_buffer,
  output logic [MEM_ADDRESS_WIDTH-1:0]           o_mem_addr,
  output logic [WORD_SIZE-1:0]                   o_mem_data,
  output logic                                   o_mem_write,
  output logic                                   o_busy,
  output logic                                   o_ready
);
  import dma_pkg::*;

  localparam int CNT_W = MEM_ADDRESS_WIDTH + 1;
  localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  dma_state_t                            state;
  logic [MEM_ADDRESS_WIDTH-1:0]          addr_q;
  logic [CNT_W-1:0]                      remaining_q;
  logic [IDX_W-1:0]                      idx_q;
  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0] snap_q;
  logic [CNT_W-1:0]                      eff_count;

  assign eff_count = CNT_W'(clamp_count(int'(i_count), BUFFER_SIZE));

  // NOTE: the snapshot is a wide data store, not control state; it is only
  // read after being loaded at acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && i_write) begin
      snap_q <= i_buffer;
    end
  end

  // NOTE: every register here uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_mem_write <= 1'b0;
      o_busy      <= 1'b0;
      o_ready     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_mem_write <= 1'b0;
          o_ready     <= 1'b0;
          if (i_write) begin
            addr_q      <= i_address;
            remaining_q <= eff_count;
            idx_q       <= '0;
            o_mem_data  <= i_buffer[0];
            o_busy      <= (eff_count != '0);
            state       <= (eff_count == '0) ? DONE : WRITE;
          end
        end

        WRITE: begin
          // Outputs registered here appear in the cycle after this edge.
          o_mem_write <= 1'b1;
          o_mem_addr  <= addr_q;
          o_mem_data  <= snap_q[idx_q];
          addr_q      <= addr_q + MEM_ADDRESS_WIDTH'(1);
          idx_q       <= idx_q + IDX_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          o_mem_write <= 1'b0;
          o_busy      <= 1'b0;
          // o_ready is shown for at least one cycle, then held until the
          // request level drops so a held i_write does not retrigger.
          if (!o_ready) begin
            o_ready <= 1'b1;
          end else if (!i_write) begin
            o_ready <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_writer.sv
// Randomised and directed checks of dma_writer against a word-level memory
// model: each request writes buf[k] to (addr+k) mod depth for k < min(count, size).
module tb_dma_writer;
  localparam int BS    = 120;
  localparam int WS    = 16;
  localparam int AW    = 3;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int SBS   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      i_write;
  logic [AW-1:0]             i_address;
  logic [CW-1:0]             i_count;
  logic [0:BS-1][WS-1:0]     i_buffer;
  logic [AW-1:0]             o_mem_addr;
  logic [WS-1:0]             o_mem_data;
  logic                      o_mem_write, o_busy, o_ready;

  logic                      s_write;
  logic [AW-1:0]             s_address;
  logic [CW-1:0]             s_count;
  logic [0:SBS-1][WS-1:0]    s_buffer;
  logic [AW-1:0]             s_mem_addr;
  logic [WS-1:0]             s_mem_data;
  logic                      s_mem_write, s_busy, s_ready;

  dma_writer #(.BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_write(i_write), .i_address(i_address),
    .i_count(i_count), .i_buffer(i_buffer), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_write(o_mem_write), .o_busy(o_busy),
    .o_ready(o_ready)
  );

  dma_writer #(.BUFFER_SIZE(SBS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) dut_small (
    .clk(clk), .rst(rst), .i_write(s_write), .i_address(s_address),
    .i_count(s_count), .i_buffer(s_buffer), .o_mem_addr(s_mem_addr),
    .o_mem_data(s_mem_data), .o_mem_write(s_mem_write), .o_busy(s_busy),
    .o_ready(s_ready)
  );

  // Bench-side memories, written only by the DUT write ports.
  logic [WS-1:0] mem   [DEPTH] = '{default: '0};
  logic [WS-1:0] s_mem [DEPTH] = '{default: '0};
  int            n_writes   = 0;
  int            s_n_writes = 0;
  int            addr_log[$];

  always @(posedge clk) begin
    if (o_mem_write) begin
      mem[o_mem_addr] <= o_mem_data;
      n_writes++;
      addr_log.push_back(int'(o_mem_addr));
    end
  end

  always @(posedge clk) begin
    if (s_mem_write) begin
      s_mem[s_mem_addr] <= s_mem_data;
      s_n_writes++;
    end
  end

  // Reference model state.
  logic [WS-1:0] exp_mem [DEPTH] = '{default: '0};
  logic [WS-1:0] bm [DEPTH];
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_buffer();
    for (int k = 0; k < BS; k++) begin
      i_buffer[k] = (k < DEPTH) ? bm[k] : WS'($urandom);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s mem[%0d]", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    end
  endtask

  task automatic run_transfer(input string tag, input int addr, input int cnt, input bit corrupt);
    int w0, a0, edge_n, n_eff, got_a;
    n_eff  = (cnt < BS) ? cnt : BS;
    w0     = n_writes;
    a0     = addr_log.size();
    edge_n = -1;
    @(negedge clk);
    i_address = AW'(addr);
    i_count   = CW'(cnt);
    i_write   = 1'b1;
    @(posedge clk);
    if (corrupt) begin
      @(negedge clk);
      i_buffer = '1;
    end
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (o_ready) begin
        edge_n = e;
        break;
      end
    end
    check({tag, " ready_edge"}, edge_n, n_eff + 1);
    check({tag, " writes"}, n_writes - w0, n_eff);
    check({tag, " busy_at_ready"}, o_busy, 1'b0);
    for (int k = 0; k < n_eff; k++) begin
      exp_mem[(addr + k) % DEPTH] = bm[k];
      got_a = (a0 + k < addr_log.size()) ? addr_log[a0 + k] : -1;
      check($sformatf("%s addr[%0d]", tag, k), got_a, (addr + k) % DEPTH);
    end
    check_mem(tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " ready_held"}, o_ready, 1'b1);
    check({tag, " no_retrigger"}, n_writes - w0, n_eff);
    @(negedge clk);
    i_write = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready_drop"}, o_ready, 1'b0);
    if (corrupt) set_buffer();
  endtask

  initial begin
    int w0, edge_n;
    rst = 1'b1; i_write = 1'b0; i_address = '0; i_count = '0; i_buffer = '0;
    s_write = 1'b0; s_address = '0; s_count = '0; s_buffer = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset write", o_mem_write, 1'b0);
    check("reset busy", o_busy, 1'b0);
    check("reset ready", o_ready, 1'b0);
    check("reset addr", o_mem_addr, 0);
    check("reset data", o_mem_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) bm[k] = WS'(16'hA0 + k);
    set_buffer();
    run_transfer("basic", 1, 4, 1'b0);
    run_transfer("wrap", 6, 4, 1'b0);
    run_transfer("zero", 3, 0, 1'b0);
    run_transfer("snap", 2, 4, 1'b1);
    run_transfer("snap_again", 2, 4, 1'b0);

    // Reset after three writes of an eight-word transfer.
    for (int k = 0; k < DEPTH; k++) bm[k] = WS'(16'hC0 + k);
    set_buffer();
    w0 = n_writes;
    @(negedge clk);
    i_address = '0; i_count = CW'(8); i_write = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort write", o_mem_write, 1'b0);
    check("abort busy", o_busy, 1'b0);
    check("abort ready", o_ready, 1'b0);
    check("abort addr", o_mem_addr, 0);
    check("abort data", o_mem_data, 0);
    @(negedge clk);
    rst = 1'b0; i_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort writes", n_writes - w0, 3);
    check("abort idle", o_busy, 1'b0);
    for (int k = 0; k < 3; k++) exp_mem[k] = bm[k];
    check_mem("abort");
    run_transfer("post_reset", 3, 2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < DEPTH; k++) bm[k] = WS'($urandom);
      set_buffer();
      run_transfer($sformatf("rand%0d", r), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, DEPTH)), 1'b0);
    end

    // Clamp: a four-word buffer with a request for eight words.
    for (int k = 0; k < SBS; k++) s_buffer[k] = WS'(16'hB0 + k);
    w0 = s_n_writes;
    edge_n = -1;
    @(negedge clk);
    s_address = AW'(5); s_count = CW'(8); s_write = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (s_ready) begin
        edge_n = e;
        break;
      end
    end
    check("clamp ready_edge", edge_n, SBS + 1);
    check("clamp writes", s_n_writes - w0, SBS);
    for (int k = 0; k < SBS; k++) begin
      check($sformatf("clamp mem[%0d]", (5 + k) % DEPTH), 32'(s_mem[(5 + k) % DEPTH]), 32'(16'hB0 + k));
    end
    check("clamp untouched", 32'(s_mem[1]), 0);
    @(negedge clk);
    s_write = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_writer.md
Name: dma_writer

Overview:
- Write-direction counterpart of the DMA reader: drains a packed word buffer into word-addressed memory, starting at a given address, for a given word count.
- Sits between the FC/conv result buffers and the shared memory. It drives the memory's address, data and write-enable.
- Uses the same start-level / o_ready handshake as the reader, so control FSMs treat both blocks the same way.

Parameters:
- BUFFER_SIZE, 120, number of words in i_buffer.
- WORD_SIZE, 16, bits per word.
- MEM_ADDRESS_WIDTH, 3, memory address width; memory depth is 2**MEM_ADDRESS_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_write  input  1  start request; level, sampled in IDLE.
- i_address  input  MEM_ADDRESS_WIDTH  first memory address to write.
- i_count  input  MEM_ADDRESS_WIDTH+1  number of words to write (0..2**MEM_ADDRESS_WIDTH).
- i_buffer  input  [0:BUFFER_SIZE-1][WORD_SIZE-1:0]  source words; word 0 is written first.
- o_mem_addr  output  MEM_ADDRESS_WIDTH  memory write address.
- o_mem_data  output  WORD_SIZE  memory write data.
- o_mem_write  output  1  memory write enable; memory commits on a clk edge where it is 1.
- o_busy  output  1  transfer in progress.
- o_ready  output  1  transfer complete.

Behaviour:
- Reset is synchronous, active-high.
  - On a clk edge with rst=1: state=IDLE; o_mem_write, o_busy, o_ready = 0; o_mem_addr, o_mem_data = 0; internal counters = 0.
  - rst takes priority over every other input.
  - Reset during WRITE aborts the transfer. No o_mem_write pulse occurs in the cycle after the reset edge.
- All outputs are registered; no combinational path from any input to any output.
- FSM states (enum in package): IDLE, WRITE, DONE.
- IDLE:
  - On an edge with i_write=1, latch i_address into the address register and the effective count into the remaining-words register.
  - Also snapshot the first word, buffer[0], into the output data register. Later changes to i_buffer during the transfer are not used. Implementation keeps a latched copy of i_buffer, taken at this edge.
  - Effective count = min(i_count, BUFFER_SIZE).
  - Effective count 0: go straight to DONE; no write is ever issued.
  - Otherwise go to WRITE.
- WRITE: one word per cycle.
  - On cycle k of the transfer (k=0 at the first WRITE cycle): o_mem_write=1, o_mem_addr=(base+k) mod 2**MEM_ADDRESS_WIDTH, o_mem_data=buffer[k], o_busy=1.
  - The address wraps naturally at MEM_ADDRESS_WIDTH bits.
  - After the word with k = count-1, go to DONE.
  - i_write is ignored while in WRITE.
- DONE:
  - o_ready=1, o_busy=0, o_mem_write=0.
  - o_mem_addr and o_mem_data hold their last values.
  - Stay in DONE while i_write=1, so a held request does not retrigger.
  - When i_write=0, return to IDLE; o_ready drops on that same edge.
- Latency, counting the accepting edge as edge 0:
  - Writes occupy the cycles after edges 1..N.
  - o_ready rises on edge N+1 (edge 1 when N=0).
  - Total transfer is N+1 cycles.

Decomposition:
- Package dma_pkg holds:
  - typedef dma_state_t {IDLE, WRITE, DONE};
  - default-width localparams shared with the DMA reader (WORD_SIZE, MEM_ADDRESS_WIDTH, BUFFER_SIZE);
  - a function for effective count (clamp to BUFFER_SIZE).
- No sub-module; the address counter and word index live in one always_ff block.

Test Plan:
- Basic transfer: bench memory of 8 words, all zero; i_buffer[k]=16'hA0+k; address=1, count=4, i_write held at 1.
  - Required: mem[1..4]=A0,A1,A2,A3, all other words 0.
  - Exactly 4 write cycles; o_ready rises 5 edges after acceptance.
- Wrap-around: address=6, count=4.
  - Required: mem[6]=A0, mem[7]=A1, mem[0]=A2, mem[1]=A3.
  - o_mem_addr sequence 6,7,0,1.
- Zero count: count=0, i_write=1.
  - Required: o_mem_write never 1; o_ready=1 on the next edge; memory unchanged.
- Snapshot and no retrigger:
  - i_buffer changes to all 16'hFFFF one cycle after acceptance; writes must still be A0..A3.
  - With i_write held high, o_ready stays 1 and no second transfer starts.
  - Dropping i_write returns the block to IDLE; re-asserting it runs a second identical transfer.
- Reset mid-transfer: address=0, count=8, rst=1 for one edge after 3 writes.
  - Required: only mem[0..2] written; all outputs 0 on the edge after rst; block idle.
  - A new request afterwards completes normally.
- Clamp: BUFFER_SIZE=4 override, count=8.
  - Required: exactly 4 writes, then o_ready.
